// File: rtl/cpu_pkg.sv
// Shared core types and constants.
// Fetch FSM states, default widths and the fault NOP word.
package cpu_pkg;

  localparam int ADD_WIDTH  = 32;
  localparam int INST_WIDTH = 32;

  // andi r0,r0,0
  localparam logic [31:0] NOP_INST = 32'h0340_0000;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    DROP
  } fetch_state_t;

endpackage

// File: rtl/fetch_timeout_cnt.sv
// Bus-timeout counter: sync clear, count enable, terminal count.
// Ports: clk, rstn, clr_i, en_i in; tc_o high when count == TIMEOUT-1.
module fetch_timeout_cnt #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rstn,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);

  localparam int CW = $clog2(TIMEOUT);

  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (en_i) begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

  assign tc_o = (cnt_q == CW'(TIMEOUT - 1));

endmodule

// File: rtl/inst_fetch_unit.sv
// Instruction fetch stage: PC -> imem req/ack -> IR, with flush/timeout.
// Ports: control (fetch_start, flush), imem handshake, IR + status pulses.
module inst_fetch_unit #(
  parameter int ADD_WIDTH  = cpu_pkg::ADD_WIDTH,
  parameter int INST_WIDTH = cpu_pkg::INST_WIDTH,
  parameter int TIMEOUT    = 16,
  parameter logic [INST_WIDTH-1:0] NOP_INST = cpu_pkg::NOP_INST
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic [ADD_WIDTH-1:0]  pc_in,
  input  logic                  fetch_start,
  input  logic                  flush,
  output logic                  imem_req,
  output logic [ADD_WIDTH-1:0]  imem_addr,
  input  logic                  imem_ack,
  input  logic [INST_WIDTH-1:0] imem_rdata,
  input  logic                  imem_err,
  output logic [INST_WIDTH-1:0] ir_out,
  output logic [ADD_WIDTH-1:0]  ir_pc,
  output logic                  ir_valid,
  output logic                  fetch_busy,
  output logic                  fetch_done,
  output logic                  exc_adef,
  output logic                  exc_bus
);

  import cpu_pkg::*;

  fetch_state_t state_q;

  logic                  req_q;
  logic [ADD_WIDTH-1:0]  addr_q;
  logic [INST_WIDTH-1:0] ir_q;
  logic [ADD_WIDTH-1:0]  ir_pc_q;
  logic                  ir_valid_q;
  logic                  done_q;
  logic                  adef_q;
  logic                  bus_q;
  logic                  tmo;

  // Held clear in IDLE so every REQ entry starts from zero;
  // keeps running through DROP to bound the abandoned request.
  fetch_timeout_cnt #(
    .TIMEOUT (TIMEOUT)
  ) u_tmo (
    .clk   (clk),
    .rstn  (rstn),
    .clr_i (state_q == IDLE),
    .en_i  ((state_q != IDLE) && !imem_ack),
    .tc_o  (tmo)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= IDLE;
      req_q      <= 1'b0;
      addr_q     <= '0;
      ir_q       <= NOP_INST;
      ir_pc_q    <= '0;
      ir_valid_q <= 1'b0;
      done_q     <= 1'b0;
      adef_q     <= 1'b0;
      bus_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      adef_q <= 1'b0;
      bus_q  <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (flush) begin
            ir_valid_q <= 1'b0;
          end else if (fetch_start) begin
            ir_valid_q <= 1'b0;
            if (|pc_in[1:0]) begin
              adef_q  <= 1'b1;
              done_q  <= 1'b1;
              ir_q    <= NOP_INST;
              ir_pc_q <= pc_in;
            end else begin
              addr_q  <= pc_in;
              req_q   <= 1'b1;
              state_q <= REQ;
            end
          end
        end
        REQ: begin
          if (imem_ack) begin
            req_q   <= 1'b0;
            state_q <= IDLE;
            if (imem_err) begin
              ir_q       <= NOP_INST;
              ir_valid_q <= 1'b0;
              bus_q      <= 1'b1;
              done_q     <= 1'b1;
            end else if (flush) begin
              ir_valid_q <= 1'b0;
            end else begin
              ir_q       <= imem_rdata;
              ir_pc_q    <= addr_q;
              ir_valid_q <= 1'b1;
              done_q     <= 1'b1;
            end
          end else if (flush) begin
            // Request stays up until acked; only a
            // coincident timeout may drop it here.
            ir_valid_q <= 1'b0;
            if (tmo) begin
              req_q   <= 1'b0;
              state_q <= IDLE;
            end else begin
              state_q <= DROP;
            end
          end else if (tmo) begin
            req_q      <= 1'b0;
            state_q    <= IDLE;
            ir_q       <= NOP_INST;
            ir_valid_q <= 1'b0;
            bus_q      <= 1'b1;
            done_q     <= 1'b1;
          end
        end
        DROP: begin
          if (imem_ack || tmo) begin
            req_q   <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: begin
          req_q   <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign imem_req   = req_q;
  assign imem_addr  = addr_q;
  assign ir_out     = ir_q;
  assign ir_pc      = ir_pc_q;
  assign ir_valid   = ir_valid_q;
  assign fetch_done = done_q;
  assign exc_adef   = adef_q;
  assign exc_bus    = bus_q;
  assign fetch_busy = (state_q != IDLE);

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Self-checking bench for inst_fetch_unit: vector table,
// directed multi-cycle sequences and a randomized model run.
module tb_inst_fetch_unit;

  localparam int          TMO = 16;
  localparam logic [31:0] NOP = 32'h0340_0000;

  logic        clk;
  logic        rstn;
  logic [31:0] pc_in;
  logic        fetch_start;
  logic        flush;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        imem_err;
  logic [31:0] ir_out;
  logic [31:0] ir_pc;
  logic        ir_valid;
  logic        fetch_busy;
  logic        fetch_done;
  logic        exc_adef;
  logic        exc_bus;

  int checks = 0;
  int errors = 0;

  inst_fetch_unit #(
    .TIMEOUT (TMO)
  ) dut (
    .clk         (clk),
    .rstn        (rstn),
    .pc_in       (pc_in),
    .fetch_start (fetch_start),
    .flush       (flush),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .imem_err    (imem_err),
    .ir_out      (ir_out),
    .ir_pc       (ir_pc),
    .ir_valid    (ir_valid),
    .fetch_busy  (fetch_busy),
    .fetch_done  (fetch_done),
    .exc_adef    (exc_adef),
    .exc_bus     (exc_bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        start;
    logic        flush;
    logic        ack;
    logic        err;
    logic [31:0] pc;
    logic [31:0] rdata;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_val;
    logic        e_done;
    logic        e_adef;
    logic        e_bus;
    logic [31:0] e_ir;
    logic [31:0] e_pc;
  } vec_t;

  vec_t tv[$];

  function automatic vec_t mk(
    input logic st, input logic fl, input logic ak, input logic er,
    input logic [31:0] pc, input logic [31:0] rd,
    input logic rq, input logic [31:0] ad, input logic vl,
    input logic dn, input logic af, input logic bs,
    input logic [31:0] ir, input logic [31:0] ip);
    vec_t v;
    v.start = st; v.flush = fl; v.ack = ak; v.err = er;
    v.pc = pc; v.rdata = rd;
    v.e_req = rq; v.e_addr = ad; v.e_val = vl;
    v.e_done = dn; v.e_adef = af; v.e_bus = bs;
    v.e_ir = ir; v.e_pc = ip;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string n, input logic [31:0] a,
                     input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", n, a, e);
    end
  endtask

  task automatic check_all(
    input string t, input logic rq, input logic [31:0] ad,
    input logic vl, input logic dn, input logic af, input logic bs,
    input logic [31:0] ir, input logic [31:0] ip);
    chk({t, ".req"},   32'(imem_req),   32'(rq));
    chk({t, ".addr"},  imem_addr,       ad);
    chk({t, ".valid"}, 32'(ir_valid),   32'(vl));
    chk({t, ".done"},  32'(fetch_done), 32'(dn));
    chk({t, ".adef"},  32'(exc_adef),   32'(af));
    chk({t, ".bus"},   32'(exc_bus),    32'(bs));
    chk({t, ".ir"},    ir_out,          ir);
    chk({t, ".irpc"},  ir_pc,           ip);
    chk({t, ".busy"},  32'(fetch_busy), 32'(rq));
  endtask

  task automatic drive(input logic st, input logic fl,
                       input logic [31:0] pc, input logic ak,
                       input logic er, input logic [31:0] rd);
    fetch_start = st;
    flush       = fl;
    pc_in       = pc;
    imem_ack    = ak;
    imem_err    = er;
    imem_rdata  = rd;
  endtask

  // Transaction-level reference: the request is "in flight" for
  // m_age completed cycles; it must end by ack or after TMO cycles.
  logic        m_req, m_drop, m_val;
  logic        m_done, m_adef, m_bus;
  logic [31:0] m_addr, m_ir, m_pc;
  int          m_age, m_lat;

  task automatic model_reset();
    m_req = 0; m_drop = 0; m_val = 0;
    m_done = 0; m_adef = 0; m_bus = 0;
    m_addr = 0; m_ir = NOP; m_pc = 0;
    m_age = 0; m_lat = 0;
  endtask

  task automatic model_step();
    bit last;
    last   = (m_age >= TMO - 1);
    m_done = 0; m_adef = 0; m_bus = 0;
    if (!m_req) begin
      if (flush) m_val = 0;
      else if (fetch_start) begin
        m_val = 0;
        if (pc_in % 4 != 0) begin
          m_adef = 1; m_done = 1; m_ir = NOP; m_pc = pc_in;
        end else begin
          m_req = 1; m_drop = 0; m_age = 0; m_addr = pc_in;
          m_lat = ($urandom % 5 == 0) ? $urandom_range(10, 20)
                                      : $urandom_range(0, 4);
        end
      end
    end else if (imem_ack) begin
      m_req = 0;
      if (!m_drop) begin
        if (imem_err) begin
          m_ir = NOP; m_val = 0; m_bus = 1; m_done = 1;
        end else if (flush) m_val = 0;
        else begin
          m_ir = imem_rdata; m_pc = m_addr; m_val = 1; m_done = 1;
        end
      end
    end else if (m_drop) begin
      if (last) m_req = 0; else m_age++;
    end else if (flush) begin
      m_val = 0;
      if (last) m_req = 0;
      else begin m_drop = 1; m_age++; end
    end else if (last) begin
      m_req = 0; m_bus = 1; m_done = 1; m_ir = NOP; m_val = 0;
    end else m_age++;
  endtask

  initial begin
    rstn = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    #12;
    check_all("reset", 0, 0, 0, 0, 0, 0, NOP, 0);
    @(negedge clk);
    rstn = 1'b1;
    tick();

    // Vector table: one row per clock edge.
    tv.push_back(mk(1,0,0,0,32'h1c000000,0,            1,32'h1c000000,0,0,0,0,NOP,0));
    tv.push_back(mk(0,0,1,0,0,32'h02800421,            0,32'h1c000000,1,1,0,0,32'h02800421,32'h1c000000));
    tv.push_back(mk(0,0,0,0,0,0,                       0,32'h1c000000,1,0,0,0,32'h02800421,32'h1c000000));
    tv.push_back(mk(1,0,0,0,32'h1c000002,0,            0,32'h1c000000,0,1,1,0,NOP,32'h1c000002));
    tv.push_back(mk(0,0,0,0,0,0,                       0,32'h1c000000,0,0,0,0,NOP,32'h1c000002));
    tv.push_back(mk(1,0,0,0,32'h1c000004,0,            1,32'h1c000004,0,0,0,0,NOP,32'h1c000002));
    tv.push_back(mk(0,0,0,0,0,0,                       1,32'h1c000004,0,0,0,0,NOP,32'h1c000002));
    tv.push_back(mk(0,0,0,0,0,0,                       1,32'h1c000004,0,0,0,0,NOP,32'h1c000002));
    tv.push_back(mk(0,0,0,0,0,0,                       1,32'h1c000004,0,0,0,0,NOP,32'h1c000002));
    tv.push_back(mk(0,0,1,0,0,32'h28c00000,            0,32'h1c000004,1,1,0,0,32'h28c00000,32'h1c000004));
    tv.push_back(mk(1,0,0,0,32'h1c000008,0,            1,32'h1c000008,0,0,0,0,32'h28c00000,32'h1c000004));
    tv.push_back(mk(1,0,0,0,32'h1c00000c,0,            1,32'h1c000008,0,0,0,0,32'h28c00000,32'h1c000004));
    tv.push_back(mk(0,0,1,1,0,32'haaaa0000,            0,32'h1c000008,0,1,0,1,NOP,32'h1c000004));
    tv.push_back(mk(1,1,0,0,32'h1c000010,0,            0,32'h1c000008,0,0,0,0,NOP,32'h1c000004));
    tv.push_back(mk(0,0,0,0,0,0,                       0,32'h1c000008,0,0,0,0,NOP,32'h1c000004));
    tv.push_back(mk(1,0,0,0,32'h1c000014,0,            1,32'h1c000014,0,0,0,0,NOP,32'h1c000004));
    tv.push_back(mk(0,0,1,0,0,32'h11111111,            0,32'h1c000014,1,1,0,0,32'h11111111,32'h1c000014));
    tv.push_back(mk(0,1,0,0,0,0,                       0,32'h1c000014,0,0,0,0,32'h11111111,32'h1c000014));
    tv.push_back(mk(1,0,0,0,32'h1c000018,0,            1,32'h1c000018,0,0,0,0,32'h11111111,32'h1c000014));
    tv.push_back(mk(0,1,1,0,0,32'h22222222,            0,32'h1c000018,0,0,0,0,32'h11111111,32'h1c000014));

    foreach (tv[i]) begin
      drive(tv[i].start, tv[i].flush, tv[i].pc,
            tv[i].ack, tv[i].err, tv[i].rdata);
      tick();
      check_all($sformatf("vec%0d", i), tv[i].e_req, tv[i].e_addr,
                tv[i].e_val, tv[i].e_done, tv[i].e_adef,
                tv[i].e_bus, tv[i].e_ir, tv[i].e_pc);
    end

    // Flush while outstanding: DROP keeps req, late data discarded.
    drive(1, 0, 32'h1c000040, 0, 0, 0); tick();
    drive(0, 0, 0, 1, 0, 32'h12345678); tick();
    check_all("pre_drop", 0, 32'h1c000040, 1, 1, 0, 0, 32'h12345678, 32'h1c000040);
    drive(1, 0, 32'h1c000044, 0, 0, 0); tick();
    drive(0, 0, 0, 0, 0, 0); tick();
    drive(0, 1, 0, 0, 0, 0); tick();
    check_all("drop_enter", 1, 32'h1c000044, 0, 0, 0, 0, 32'h12345678, 32'h1c000040);
    drive(0, 0, 0, 0, 0, 0); tick(); tick();
    check_all("drop_wait", 1, 32'h1c000044, 0, 0, 0, 0, 32'h12345678, 32'h1c000040);
    drive(0, 0, 0, 1, 0, 32'hdeadbeef); tick();
    check_all("drop_ack", 0, 32'h1c000044, 0, 0, 0, 0, 32'h12345678, 32'h1c000040);
    drive(0, 0, 0, 0, 0, 0); tick();
    check_all("drop_after", 0, 32'h1c000044, 0, 0, 0, 0, 32'h12345678, 32'h1c000040);

    // No ack: request may stay up exactly TMO cycles.
    drive(1, 0, 32'h1c000080, 0, 0, 0); tick();
    drive(0, 0, 0, 0, 0, 0);
    for (int i = 1; i < TMO; i++) begin
      tick();
      chk($sformatf("tmo_hold%0d", i), 32'(imem_req), 32'd1);
    end
    tick();
    check_all("tmo_fire", 0, 32'h1c000080, 0, 1, 0, 1, NOP, 32'h1c000040);
    tick();
    check_all("tmo_after", 0, 32'h1c000080, 0, 0, 0, 0, NOP, 32'h1c000040);

    // Async reset mid-REQ, then a normal fetch.
    drive(1, 0, 32'h1c000100, 0, 0, 0); tick();
    drive(0, 0, 0, 1, 0, 32'h29800000); tick();
    drive(1, 0, 32'h1c000104, 0, 0, 0); tick();
    drive(0, 0, 0, 0, 0, 0); tick();
    chk("rst_pre.req", 32'(imem_req), 32'd1);
    rstn = 1'b0;
    #2;
    check_all("rst_async", 0, 0, 0, 0, 0, 0, NOP, 0);
    @(negedge clk);
    rstn = 1'b1;
    tick();
    drive(1, 0, 32'h1c000108, 0, 0, 0); tick();
    check_all("rst_f1", 1, 32'h1c000108, 0, 0, 0, 0, NOP, 0);
    drive(0, 0, 0, 1, 0, 32'h02800421); tick();
    check_all("rst_f2", 0, 32'h1c000108, 1, 1, 0, 0, 32'h02800421, 32'h1c000108);

    // Randomized run against the reference model.
    drive(0, 0, 0, 0, 0, 0);
    rstn = 1'b0;
    #3;
    rstn = 1'b1;
    model_reset();
    for (int c = 0; c < 3000; c++) begin
      logic [31:0] pc;
      logic        ak;
      pc = $urandom;
      if ($urandom % 8 != 0) pc[1:0] = 2'b00;
      ak = m_req && (m_age >= m_lat);
      fetch_start = ($urandom % 3 == 0);
      flush       = ($urandom % 12 == 0);
      pc_in       = pc;
      imem_ack    = ak;
      imem_err    = ak && !flush && ($urandom % 6 == 0);
      imem_rdata  = $urandom;
      model_step();
      tick();
      check_all($sformatf("rnd%0d", c), m_req, m_addr, m_val,
                m_done, m_adef, m_bus, m_ir, m_pc);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/inst_fetch_unit.md
Name: inst_fetch_unit

Overview:
- Instruction-fetch stage of the multi-cycle LoongArch-style core. Sits directly downstream of the PC register.
- On a fetch request from the control unit, it takes the current PC and issues a request to instruction memory over a req/ack handshake. It latches the returned word into the instruction register (IR) with its PC, then signals completion so the control unit can advance its step counter.
- Handles variable-latency memory, flush on taken jump, misaligned PC and bus timeout.

Parameters:
- ADD_WIDTH, 32, PC / memory address width
- INST_WIDTH, 32, instruction word width
- TIMEOUT, 16, max cycles imem_req may stay high without imem_ack before a bus error is raised (>=2)
- NOP_INST, 32'h03400000, word loaded into IR on any fetch fault (andi r0,r0,0)

Ports:
- clk  input  1  system clock, rising edge
- rstn  input  1  asynchronous active-low reset
- pc_in  input  ADD_WIDTH  current PC from PC register
- fetch_start  input  1  one-cycle pulse from control unit: begin fetch of pc_in
- flush  input  1  taken jump/redirect: abandon current fetch
- imem_req  output  1  registered request to instruction memory
- imem_addr  output  ADD_WIDTH  registered address, stable while imem_req=1
- imem_ack  input  1  memory completes request this cycle
- imem_rdata  input  INST_WIDTH  instruction data, valid when imem_ack=1
- imem_err  input  1  memory error, qualified by imem_ack
- ir_out  output  INST_WIDTH  instruction register
- ir_pc  output  ADD_WIDTH  PC of instruction in ir_out
- ir_valid  output  1  ir_out holds a fetched, unflushed instruction
- fetch_busy  output  1  high when not IDLE
- fetch_done  output  1  one-cycle pulse: fetch finished (success or fault)
- exc_adef  output  1  one-cycle pulse: pc_in[1:0]!=0 at fetch_start
- exc_bus  output  1  one-cycle pulse: imem_err or timeout

Behaviour:
- Reset (async, rstn=0):
  - State goes to IDLE.
  - imem_req=0, imem_addr=0, ir_out=NOP_INST, ir_pc=0, ir_valid=0.
  - fetch_done, exc_adef and exc_bus are all 0; timeout count is 0.
  - Reset mid-fetch drops imem_req immediately. No handshake completion is required.
- States:
  - IDLE: waiting for fetch_start.
  - REQ: request outstanding.
  - DROP: flushed while outstanding; waiting for the ack to discard it.
- IDLE with fetch_start=1, flush=0:
  - ir_valid<=0.
  - If pc_in[1:0]!=0: exc_adef<=1, fetch_done<=1, ir_out<=NOP_INST, ir_pc<=pc_in; stay IDLE; no memory request.
  - Else: imem_addr<=pc_in, imem_req<=1, go to REQ.
- IDLE with fetch_start and flush both high: flush wins. No fetch starts and ir_valid<=0.
- REQ, sampled each rising edge:
  - imem_ack=1 and flush=0 and imem_err=0: ir_out<=imem_rdata, ir_pc<=imem_addr, ir_valid<=1, fetch_done<=1, imem_req<=0; go to IDLE.
  - imem_ack=1 and imem_err=1: ir_out<=NOP_INST, ir_valid<=0, exc_bus<=1, fetch_done<=1, imem_req<=0; go to IDLE.
  - imem_ack=1 and flush=1: data discarded, imem_req<=0, ir_valid<=0; go to IDLE. No fetch_done, no exception.
  - imem_ack=0 and flush=1: keep imem_req=1 (requests are never retracted) and go to DROP; ir_valid<=0.
  - imem_ack=0, flush=0: count++. If count reaches TIMEOUT-1: imem_req<=0, exc_bus<=1, fetch_done<=1, ir_out<=NOP_INST, ir_valid<=0; go to IDLE. The memory must treat a dropped req as cancelled.
- DROP:
  - On imem_ack: imem_req<=0; go to IDLE; data ignored.
  - On timeout: imem_req<=0; go to IDLE, silently.
- Timeout counter clears on entry to REQ.
- fetch_start outside IDLE is ignored. flush in IDLE only clears ir_valid.
- Latency with a zero-wait memory (ack in the first req cycle):
  - fetch_start at edge N; imem_req high in cycle N+1; ack sampled at edge N+1.
  - ir_valid and fetch_done visible in cycle N+2.
  - Minimum fetch is 2 cycles.
- Output timing: fetch_done, exc_adef and exc_bus are registered single-cycle pulses. fetch_busy is the combinational decode (state!=IDLE).

Decomposition:
- Shared package (cpu_pkg) holds:
  - the fetch_state_t enum {IDLE, REQ, DROP};
  - the NOP_INST constant;
  - the ADD_WIDTH and INST_WIDTH defaults.
- One sub-module, fetch_timeout_cnt: a clear/enable counter of width $clog2(TIMEOUT) with a terminal-count output, reset asynchronously by rstn.

Test Plan:
- Zero-wait fetch: pc_in=32'h1c000000, fetch_start, ack with rdata=32'h02800421 in the first req cycle -> in cycle N+2, ir_out=32'h02800421, ir_pc=32'h1c000000, ir_valid=1, one-cycle fetch_done.
- 3-cycle wait memory at pc_in=32'h1c000004 -> imem_req held 4 cycles with imem_addr stable; ir_valid follows the edge after ack; no exc_bus.
- Misaligned pc_in=32'h1c000002 -> exc_adef and fetch_done pulse together one cycle after start; imem_req never rises; ir_out=32'h03400000.
- Flush at cycle 2 of a wait-state fetch -> go to DROP with req still high; ack later with rdata=32'hdeadbeef -> ir_valid stays 0, ir_out unchanged, no fetch_done.
- No ack with TIMEOUT=16 -> after 16 cycles imem_req=0, exc_bus and fetch_done pulse, ir_out=NOP_INST; imem_err with ack gives the same result.
- rstn low mid-REQ -> imem_req=0 and ir_valid=0 asynchronously, before the next edge; after release, a new fetch_start completes normally.
